// File: rtl/push_conditioner.sv
// Conditions raw push buttons: 2-flop sync, debounce, press/release strobes
// and optional auto-repeat while a button is held. Each button is independent.
module push_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int CNT_W           = 26
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] push_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] push_level,
  output logic [N_BTN-1:0] push_pulse,
  output logic [N_BTN-1:0] push_release
);

  typedef enum logic [1:0] {
    RELEASED,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } btn_state_t;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_MAX  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_BTN-1:0] sync_1;
  logic [N_BTN-1:0] sync_2;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= push_raw;
      sync_2 <= sync_1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_t       state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             first_rep;
    logic             level_q;
    logic             pulse_q;
    logic             release_q;
    logic             rep_match;

    assign rep_match = (rep_cnt == (first_rep ? DELAY_MAX : RATE_MAX));

    // The repeat counter is cleared on every match even when repeat is
    // disabled, so enabling it later fires at the next natural match.
    always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
        state     <= RELEASED;
        deb_cnt   <= '0;
        rep_cnt   <= '0;
        first_rep <= 1'b1;
        level_q   <= 1'b0;
        pulse_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        pulse_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          RELEASED: begin
            if (sync_2[i]) begin
              state   <= DEB_PRESS;
              deb_cnt <= '0;
            end
          end
          DEB_PRESS: begin
            if (!sync_2[i]) begin
              state <= RELEASED;
            end else if (deb_cnt == DEB_MAX) begin
              state     <= PRESSED;
              level_q   <= 1'b1;
              pulse_q   <= 1'b1;
              rep_cnt   <= '0;
              first_rep <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!sync_2[i]) begin
              state   <= DEB_RELEASE;
              deb_cnt <= '0;
            end else if (rep_match) begin
              pulse_q   <= repeat_en[i];
              rep_cnt   <= '0;
              first_rep <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
            end
          end
          DEB_RELEASE: begin
            if (sync_2[i]) begin
              state <= PRESSED;
            end else if (deb_cnt == DEB_MAX) begin
              state     <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              deb_cnt <= deb_cnt + CNT_ONE;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end

    assign push_level[i]   = level_q;
    assign push_pulse[i]   = pulse_q;
    assign push_release[i] = release_q;
  end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner with short debounce/repeat timings;
// each scenario task checks its own expected values cycle by cycle.
module tb_push_conditioner;

  localparam int N_BTN = 5;

  logic             clk;
  logic             Reset;
  logic [N_BTN-1:0] push_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] push_level;
  logic [N_BTN-1:0] push_pulse;
  logic [N_BTN-1:0] push_release;

  int testsRun = 0;
  int testsFailed = 0;

  push_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .push_raw    (push_raw),
    .repeat_en   (repeat_en),
    .push_level  (push_level),
    .push_pulse  (push_pulse),
    .push_release(push_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: active edge then sample on the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) stepCycle();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    push_raw = '0;
    repeat_en = '0;
    idleCycles(2);
    testsRun++;
    if ({push_level, push_pulse, push_release} !== 15'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b, expected 0", {push_level, push_pulse, push_release});
    end
    Reset = 1'b0;
    idleCycles(2);
  endtask

  task automatic test_clean_press();
    push_raw = 5'b00100;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      testsRun++;
      if (push_pulse !== ((k == 7) ? 5'b00100 : 5'b00000) ||
          push_level !== ((k >= 7) ? 5'b00100 : 5'b00000) || push_release !== 5'b0) begin
        testsFailed++;
        $display("[TB] FAIL clean_press k=%0d: pulse=%b level=%b rel=%b", k, push_pulse, push_level, push_release);
      end
    end
    push_raw = '0;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      testsRun++;
      if (push_release !== ((k == 7) ? 5'b00100 : 5'b00000) ||
          push_level !== ((k < 7) ? 5'b00100 : 5'b00000) || push_pulse !== 5'b0) begin
        testsFailed++;
        $display("[TB] FAIL clean_release k=%0d: pulse=%b level=%b rel=%b", k, push_pulse, push_level, push_release);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses;
    push_raw = 5'b00001; idleCycles(2);
    push_raw = 5'b00000; idleCycles(1);
    push_raw = 5'b00001; idleCycles(2);
    push_raw = 5'b00000;
    for (int k = 1; k <= 10; k++) begin
      stepCycle();
      testsRun++;
      if (push_pulse !== 5'b0 || push_level !== 5'b0) begin
        testsFailed++;
        $display("[TB] FAIL bounce k=%0d: pulse=%b level=%b, expected 0", k, push_pulse, push_level);
      end
    end
    pulses = 0;
    push_raw = 5'b00001;
    for (int k = 1; k <= 12; k++) begin
      stepCycle();
      if (push_pulse[0]) pulses++;
    end
    testsRun++;
    if (pulses != 1 || push_level !== 5'b00001) begin
      testsFailed++;
      $display("[TB] FAIL bounce_stable: pulses=%0d level=%b, expected 1 and 00001", pulses, push_level);
    end
    push_raw = '0;
    idleCycles(10);
  endtask

  task automatic test_auto_repeat();
    logic [N_BTN-1:0] expPulse;
    repeat_en = 5'b01000;
    push_raw = 5'b01000;
    for (int k = 1; k <= 80; k++) begin
      stepCycle();
      if (k == 60) push_raw = '0;
      expPulse = (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59) ? 5'b01000 : 5'b0;
      testsRun++;
      if (push_pulse !== expPulse || push_release !== ((k == 67) ? 5'b01000 : 5'b0) ||
          push_level !== ((k >= 7 && k < 67) ? 5'b01000 : 5'b0)) begin
        testsFailed++;
        $display("[TB] FAIL auto_repeat k=%0d: pulse=%b (exp %b) level=%b rel=%b", k, push_pulse, expPulse, push_level, push_release);
      end
    end
    repeat_en = '0;
  endtask

  task automatic test_release_glitch();
    push_raw = 5'b00010;
    idleCycles(10);
    push_raw = '0;
    idleCycles(2);
    push_raw = 5'b00010;
    for (int k = 1; k <= 12; k++) begin
      stepCycle();
      testsRun++;
      if (push_pulse !== 5'b0 || push_release !== 5'b0 || push_level !== 5'b00010) begin
        testsFailed++;
        $display("[TB] FAIL release_glitch k=%0d: pulse=%b rel=%b level=%b", k, push_pulse, push_release, push_level);
      end
    end
    push_raw = '0;
    idleCycles(10);
  endtask

  task automatic test_simultaneous();
    push_raw = 5'b10001;
    for (int k = 1; k <= 9; k++) begin
      stepCycle();
      testsRun++;
      if (push_pulse !== ((k == 7) ? 5'b10001 : 5'b00000)) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous k=%0d: pulse=%b", k, push_pulse);
      end
    end
    push_raw = '0;
    idleCycles(10);
  endtask

  task automatic test_reset_mid();
    push_raw = 5'b00100;
    idleCycles(3);
    for (int pass = 0; pass < 2; pass++) begin
      #2 Reset = 1'b1;
      #1;
      testsRun++;
      if ({push_level, push_pulse, push_release} !== 15'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid pass=%0d: got %b, expected 0", pass, {push_level, push_pulse, push_release});
      end
      idleCycles(2);
      testsRun++;
      if ({push_level, push_pulse, push_release} !== 15'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_hold pass=%0d: got %b, expected 0", pass, {push_level, push_pulse, push_release});
      end
      Reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        stepCycle();
        testsRun++;
        if (push_pulse !== ((k == 7) ? 5'b00100 : 5'b0) || push_level !== ((k >= 7) ? 5'b00100 : 5'b0)) begin
          testsFailed++;
          $display("[TB] FAIL reset_recover pass=%0d k=%0d: pulse=%b level=%b", pass, k, push_pulse, push_level);
        end
      end
    end
    push_raw = '0;
    idleCycles(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
